// File: rtl/synth_pkg.sv
// Shared types and levels for the synth voice path.
// Envelope state encoding and full-scale sample constants.
package synth_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam logic [15:0] ENV_MAX       = 16'hFFFF;
  localparam logic [15:0] SAMPLE_POS_FS = 16'h7FFF;
  localparam logic [15:0] SAMPLE_NEG_FS = 16'h8000;

endpackage

// File: rtl/adsr_envelope_if.sv
// Control and audio bundle of the ADSR amplitude stage.
// master drives ticks, gate, rates and samples; slave is the envelope.
interface adsr_envelope_if
  import synth_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ENV_W    = 16
);
  logic                sample_tick;
  logic                gate;
  logic [ENV_W-1:0]    attack_step;
  logic [ENV_W-1:0]    decay_step;
  logic [ENV_W-1:0]    sustain_level;
  logic [ENV_W-1:0]    release_step;
  logic [SAMPLE_W-1:0] sample_in;
  logic [SAMPLE_W-1:0] sample_out;
  logic                out_valid;
  logic [ENV_W-1:0]    env_level;
  logic [2:0]          env_state;
  logic                busy;

  modport master (
    output sample_tick, gate,
    output attack_step, decay_step,
    output sustain_level, release_step,
    output sample_in,
    input  sample_out, out_valid,
    input  env_level, env_state, busy
  );

  modport slave (
    input  sample_tick, gate,
    input  attack_step, decay_step,
    input  sustain_level, release_step,
    input  sample_in,
    output sample_out, out_valid,
    output env_level, env_state, busy
  );

endinterface

// File: rtl/env_scaler.sv
// Signed sample times unsigned envelope level.
// Keeps the upper half so full-scale level never overflows.
module env_scaler #(
  parameter int SAMPLE_W = 16,
  parameter int ENV_W    = 16
) (
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic [ENV_W-1:0]    level_i,
  output logic [SAMPLE_W-1:0] sample_o
);

  localparam int PW = SAMPLE_W + ENV_W + 1;

  logic signed [PW-1:0] s_ext;
  logic signed [PW-1:0] l_ext;
  logic signed [PW-1:0] product;

  assign s_ext = $signed({{(ENV_W+1){sample_i[SAMPLE_W-1]}},
                          sample_i});
  assign l_ext = $signed({{(SAMPLE_W+1){1'b0}}, level_i});

  assign product  = s_ext * l_ext;
  assign sample_o = SAMPLE_W'(product >>> ENV_W);

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope stepped on the sample-rate strobe.
// Scales oscillator samples by the pre-update envelope level.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ENV_W    = 16
) (
  input  logic            clk,
  input  logic            reset,
  adsr_envelope_if.slave  bus
);

  env_state_t          state_q, state_d;
  logic [ENV_W-1:0]    level_q, level_d;
  logic                gate_prev_q, gate_prev_d;
  logic [SAMPLE_W-1:0] sample_out_q, sample_out_d;
  logic                out_valid_q, out_valid_d;

  logic [SAMPLE_W-1:0] scaled;
  logic                rise, fall;
  logic [ENV_W:0]      att_sum, dec_diff;
  logic                att_done, dec_done, rel_done;

  env_scaler #(
    .SAMPLE_W (SAMPLE_W),
    .ENV_W    (ENV_W)
  ) u_scaler (
    .sample_i (bus.sample_in),
    .level_i  (level_q),
    .sample_o (scaled)
  );

  assign rise = bus.gate & ~gate_prev_q;
  assign fall = ~bus.gate & gate_prev_q;

  assign att_sum  = {1'b0, level_q} + {1'b0, bus.attack_step};
  assign dec_diff = {1'b0, level_q} - {1'b0, bus.decay_step};

  assign att_done = (att_sum >= {1'b0, ENV_W'(ENV_MAX)})
                  || (bus.attack_step == '0);
  assign dec_done = ($signed(dec_diff)
                     <= $signed({1'b0, bus.sustain_level}))
                  || (bus.decay_step == '0);
  assign rel_done = (level_q <= bus.release_step)
                  || (bus.release_step == '0);

  // Next envelope state, level and output sample at each tick.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    gate_prev_d  = gate_prev_q;
    sample_out_d = sample_out_q;
    out_valid_d  = 1'b0;
    if (bus.sample_tick) begin
      gate_prev_d  = bus.gate;
      sample_out_d = scaled;
      out_valid_d  = 1'b1;
      if (rise) begin
        state_d = ATTACK;
      end else if (fall && (state_q == ATTACK
                         || state_q == DECAY
                         || state_q == SUSTAIN)) begin
        state_d = RELEASE;
      end else begin
        unique case (state_q)
          IDLE: level_d = '0;
          ATTACK: begin
            if (att_done) begin
              level_d = ENV_W'(ENV_MAX);
              state_d = DECAY;
            end else begin
              level_d = att_sum[ENV_W-1:0];
            end
          end
          DECAY: begin
            if (dec_done) begin
              level_d = bus.sustain_level;
              state_d = SUSTAIN;
            end else begin
              level_d = dec_diff[ENV_W-1:0];
            end
          end
          SUSTAIN: level_d = bus.sustain_level;
          RELEASE: begin
            if (rel_done) begin
              level_d = '0;
              state_d = IDLE;
            end else begin
              level_d = level_q - bus.release_step;
            end
          end
          default: begin
            level_d = '0;
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  // Envelope and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      level_q      <= '0;
      gate_prev_q  <= 1'b0;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      gate_prev_q  <= gate_prev_d;
      sample_out_q <= sample_out_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.sample_out = sample_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.env_level  = level_q;
  assign bus.env_state  = 3'(state_q);
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: directed envelope walk plus random
// ticks, gates, rates and resets against an integer model.
module tb_adsr_envelope;
  import synth_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  adsr_envelope_if #(.SAMPLE_W(16), .ENV_W(16)) bus ();

  adsr_envelope #(.SAMPLE_W(16), .ENV_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  bit run_cmp = 1'b0;

  int m_state, m_level, m_gprev, m_out, m_valid;

  task automatic check(input string nm, input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic from the envelope rules.
  always @(posedge clk or posedge reset) begin : model
    int g, s, att, dec, sus, rel;
    bit rise, fall;
    longint p;
    if (reset) begin
      m_state = 0; m_level = 0; m_gprev = 0;
      m_out = 0; m_valid = 0;
    end else begin
      m_valid = 0;
      if (bus.sample_tick) begin
        g   = int'(bus.gate);
        s   = int'($signed(bus.sample_in));
        att = int'(bus.attack_step);
        dec = int'(bus.decay_step);
        sus = int'(bus.sustain_level);
        rel = int'(bus.release_step);
        p = longint'(s) * longint'(m_level);
        p = p >>> 16;
        m_out = int'(p & 64'hFFFF);
        m_valid = 1;
        rise = (g == 1) && (m_gprev == 0);
        fall = (g == 0) && (m_gprev == 1);
        m_gprev = g;
        if (rise) m_state = 1;
        else if (fall && m_state >= 1 && m_state <= 3)
          m_state = 4;
        else begin
          case (m_state)
            1: if (m_level + att >= 65535 || att == 0) begin
                 m_level = 65535; m_state = 2;
               end else m_level = m_level + att;
            2: if (m_level - dec <= sus || dec == 0) begin
                 m_level = sus; m_state = 3;
               end else m_level = m_level - dec;
            3: m_level = sus;
            4: if (m_level <= rel || rel == 0) begin
                 m_level = 0; m_state = 0;
               end else m_level = m_level - rel;
            default: m_level = 0;
          endcase
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs with the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      check("state", int'(bus.env_state), m_state);
      check("level", int'(bus.env_level), m_level);
      check("sample_out", int'(bus.sample_out), m_out);
      check("out_valid", int'(bus.out_valid), m_valid);
      check("busy", int'(bus.busy), int'(m_state != 0));
    end
  end

  // One tick then gap-1 quiet cycles; ends just after a negedge.
  task automatic tick(input int gap);
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic expect_env(input string nm, input int st,
                            input int lv);
    check({nm, ".state"}, int'(bus.env_state), st);
    check({nm, ".level"}, int'(bus.env_level), lv);
  endtask

  initial begin
    bus.sample_tick   = 1'b0;
    bus.gate          = 1'b0;
    bus.attack_step   = '0;
    bus.decay_step    = '0;
    bus.sustain_level = '0;
    bus.release_step  = '0;
    bus.sample_in     = SAMPLE_POS_FS;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_cmp = 1'b1;

    check("rst.state", int'(bus.env_state), 0);
    check("rst.level", int'(bus.env_level), 0);
    check("rst.out", int'(bus.sample_out), 0);
    check("rst.valid", int'(bus.out_valid), 0);
    check("rst.busy", int'(bus.busy), 0);

    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    check("idle.out", int'(bus.sample_out), 0);
    check("idle.valid", int'(bus.out_valid), 1);
    check("idle.busy", int'(bus.busy), 0);
    @(negedge clk);
    check("idle.valid_drop", int'(bus.out_valid), 0);
    expect_env("idle", 0, 0);

    bus.attack_step = 16'h4000;
    bus.gate = 1'b1;
    tick(4); expect_env("att0", 1, 16'h0000);
    tick(4); expect_env("att1", 1, 16'h4000);
    tick(4); expect_env("att2", 1, 16'h8000);
    bus.sample_in = SAMPLE_POS_FS;
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
    check("scale_pos", int'(bus.sample_out), 16'h3FFF);
    check("scale_pos.valid", int'(bus.out_valid), 1);
    @(negedge clk);
    check("scale_pos.drop", int'(bus.out_valid), 0);
    repeat (2) @(negedge clk);
    expect_env("att3", 1, 16'hC000);
    bus.decay_step = 16'h2000;
    bus.sustain_level = 16'hA000;
    tick(4); expect_env("att4", 2, 16'hFFFF);

    bus.sample_in = SAMPLE_NEG_FS;
    tick(1);
    check("scale_neg", int'(bus.sample_out), 16'h8000);
    expect_env("dec1", 2, 16'hDFFF);
    tick(4); expect_env("dec2", 2, 16'hBFFF);
    tick(4); expect_env("dec3", 3, 16'hA000);
    bus.sustain_level = 16'h9000;
    tick(4); expect_env("sus", 3, 16'h9000);

    bus.gate = 1'b0;
    bus.release_step = 16'h5000;
    tick(4); expect_env("rel0", 4, 16'h9000);
    tick(4); expect_env("rel1", 4, 16'h4000);
    tick(4); expect_env("rel2", 0, 16'h0000);

    bus.gate = 1'b1;
    bus.attack_step = 16'h0000;
    tick(2); expect_env("att0z", 1, 16'h0000);
    tick(2); expect_env("attz", 2, 16'hFFFF);
    bus.gate = 1'b0;
    bus.release_step = 16'hBFFF;
    tick(2); expect_env("rel_a", 4, 16'hFFFF);
    tick(2); expect_env("rel_b", 4, 16'h4000);
    bus.gate = 1'b1;
    bus.attack_step = 16'h1000;
    tick(2); expect_env("regate", 1, 16'h4000);
    tick(2); expect_env("regate1", 1, 16'h5000);

    bus.attack_step = 16'h0000;
    bus.decay_step = 16'h0100;
    bus.sustain_level = 16'h0000;
    bus.sample_in = SAMPLE_POS_FS;
    tick(2); expect_env("pre_rst", 2, 16'hFFFF);
    tick(1); expect_env("mid_dec", 2, 16'hFEFF);
    #2 reset = 1'b1;
    #1;
    check("arst.state", int'(bus.env_state), 0);
    check("arst.level", int'(bus.env_level), 0);
    check("arst.out", int'(bus.sample_out), 0);
    check("arst.valid", int'(bus.out_valid), 0);
    check("arst.busy", int'(bus.busy), 0);
    bus.gate = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      bus.sample_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) bus.gate = ~bus.gate;
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.attack_step = 16'($urandom_range(0, 16'h3000));
          1: bus.decay_step = 16'($urandom_range(0, 16'h3000));
          2: bus.sustain_level = 16'($urandom);
          default:
            bus.release_step = 16'($urandom_range(0, 16'h3000));
        endcase
        if ($urandom_range(0, 7) == 0) bus.attack_step = '0;
        if ($urandom_range(0, 7) == 0) bus.release_step = '0;
      end
      case ($urandom_range(0, 5))
        0: bus.sample_in = SAMPLE_POS_FS;
        1: bus.sample_in = SAMPLE_NEG_FS;
        default: bus.sample_in = 16'($urandom);
      endcase
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
      @(negedge clk);
    end
    bus.sample_tick = 1'b0;
    @(negedge clk);
    run_cmp = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
